fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Instruction-fetch sequencer. It owns the program counter and drives the instruction-memory request interface. It presents fetched instructions to decode through a valid/stall interface. It handles branch redirects, memory wait states, decode back-pressure and end-of-program halt, and sits between the imem and the IF/ID pipeline register.

Parameters:
LAST_ADDR, 32'h0000_03FC, byte address of the final instruction; the fetch at this address is the last one.
START_ADDR, 32'h0000_0000, PC value after reset.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset_n  in  1  synchronous reset, active-low.
start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
stall  in  1  decode back-pressure; holds the if_* outputs.
branch_en  in  1  redirect request from the execute stage.
branch_target  in  16  branch byte address; zero-extended to 32 bits, bits[1:0] forced to 0.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address; always equal to pc.
imem_ready  in  1  imem accepts the request and returns data in the same cycle.
imem_rdata  in  32  instruction word; valid when imem_req && imem_ready.
if_valid  out  1  if_instr / if_pc hold a valid instruction.
if_instr  out  32  fetched instruction.
if_pc  out  32  address of if_instr.
halted  out  1  high while in HALT.
fetch_count  out  16  number of accepted (non-squashed) fetches; saturates at 16'hFFFF.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, pc=START_ADDR, imem_req=0, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0. Reset wins over every other input and may occur in any state, including mid-wait.
- Transaction: completes in a cycle where imem_req && imem_ready. Only one request is outstanding. imem_addr is stable while imem_req=1 and imem_ready=0.
- imem_req = (state==FETCH) && !(stall && if_valid). This is the only combinational output.
- States: IDLE, FETCH, HALT.
  - IDLE -> FETCH on start.
  - FETCH -> HALT when a transaction completes at pc==LAST_ADDR without branch_en.
  - HALT -> FETCH on branch_en, with pc=target.
  - start is ignored outside IDLE.
- Completed transaction (no branch_en), next cycle:
  - if_valid=1, if_instr=imem_rdata, if_pc=pc.
  - fetch_count+1.
  - pc+4 if pc<LAST_ADDR, otherwise pc is held.
  - Latency from request acceptance to if_valid is 1 cycle; throughput is 1 instr/cycle when imem_ready=1 and stall=0.
- No completion:
  - stall=1: if_* held.
  - stall=0: if_valid cleared to 0.
- branch_en (any state except IDLE), highest priority after reset:
  - pc=target next cycle.
  - if_valid=0 next cycle (squash).
  - Any same-cycle completed transaction is discarded: no if_* update, no count.
  - state=FETCH.
  - stall is overridden by the squash.
- branch_en in IDLE is ignored.
- A branch target greater than LAST_ADDR is still fetched once, then the controller enters HALT (pc>=LAST_ADDR counts as final).
- pc+4 is 32-bit; no wrap occurs because increment is gated by LAST_ADDR.

Decomposition:
- Shared package fetch_pkg: state enum (IDLE=2'd0, FETCH=2'd1, HALT=2'd2), INSTR_W=32, ADDR_W=32, BR_TGT_W=16, and the branch-target align/extend function.
- Sub-module fetch_out_reg: the IF/ID output register with hold/squash/load controls.

Test Plan:
- Reset then start, imem_ready=1, stall=0 -> imem_addr 0,4,8,… on consecutive cycles; if_pc lags by 1 cycle; fetch_count increments every cycle.
- imem_ready=0 for 3 cycles at pc=8 -> imem_req held, imem_addr=8 stable, if_valid=0 during the wait; single completion, then pc=12.
- stall=1 while if_valid=1, if_pc=4 -> imem_req=0, if_instr/if_pc held for the stall duration; resumes at 8 after stall drops.
- branch_en with branch_target=16'h0102 coinciding with a completion at pc=20 -> response discarded, if_valid=0 next cycle, next imem_addr=32'h100, count unchanged.
- Run to pc=LAST_ADDR (3FC) -> after that completion, halted=1, imem_req=0, if_pc=3FC, fetch_count=256; then branch_en target 0x40 -> FETCH resumes at 0x40, halted=0.
- reset_n=0 asserted mid-wait at pc=0x80 -> all outputs return to reset values, state=IDLE; no fetch until start.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, widths and helpers for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned BR_TGT_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_HALT  = 2'd2;

  // Branch targets are word-aligned byte addresses zero-extended to the PC width.
  function automatic logic [ADDR_W-1:0] align_target(input logic [BR_TGT_W-1:0] tgt);
    logic [BR_TGT_W-1:0] aligned;
    aligned = tgt & {{(BR_TGT_W-2){1'b1}}, 2'b00};
    return ADDR_W'(aligned);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request bus and IF/ID hand-off to decode.
interface fetch_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rdata, stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rdata, stall
  );

endinterface

// File: rtl/fetch_out_reg.sv
// IF/ID output register: squash beats load, load beats hold, otherwise valid drops.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_squash,
  input  logic               i_load,
  input  logic               i_hold,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_squash) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (!i_hold) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues imem requests, and feeds decode
// with branch squash, wait-state, back-pressure and end-of-program halt handling.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LAST_ADDR  = 32'h0000_03FC,
  parameter logic [ADDR_W-1:0] START_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                branch_en,
  input  logic [BR_TGT_W-1:0] branch_target,
  fetch_if.master             bus,
  output logic                halted,
  output logic [15:0]         fetch_count
);

  state_t            r_state;
  state_t            w_state_d;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_d;
  logic [15:0]       r_count;
  logic [15:0]       w_count_d;
  logic              r_halted;

  logic w_req;
  logic w_done;
  logic w_branch;
  logic w_final;

  // No new request while decode is holding a valid instruction.
  assign w_req    = (r_state == ST_FETCH) && !(bus.stall && bus.if_valid);
  assign w_done   = w_req && bus.imem_ready;
  assign w_branch = branch_en && (r_state != ST_IDLE);
  assign w_final  = (r_pc >= LAST_ADDR);

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_count_d = r_count;
    if (w_branch) begin
      w_state_d = ST_FETCH;
      w_pc_d    = align_target(branch_target);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) w_state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (w_done) begin
            w_count_d = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
            if (w_final) w_state_d = ST_HALT;
            else         w_pc_d    = r_pc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= START_ADDR;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_pc     <= w_pc_d;
      r_count  <= w_count_d;
      r_halted <= (w_state_d == ST_HALT);
    end
  end

  fetch_out_reg u_out_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_squash (w_branch),
    .i_load   (w_done && !w_branch),
    .i_hold   (bus.stall),
    .i_instr  (bus.imem_rdata),
    .i_pc     (r_pc),
    .o_valid  (bus.if_valid),
    .o_instr  (bus.if_instr),
    .o_pc     (bus.if_pc)
  );

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign halted        = r_halted;
  assign fetch_count   = r_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam logic [31:0] LAST = 32'h0000_03FC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        halted;
  logic [15:0] fetch_count;

  fetch_if bus();

  fetch_controller #(
    .LAST_ADDR  (LAST),
    .START_ADDR (32'h0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .bus           (bus),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 fetching, 2 halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  int          m_count;

  function automatic logic exp_req();
    return (m_mode == 1) && !(bus.stall && m_valid);
  endfunction

  task automatic model_step();
    logic        done;
    logic [31:0] tgt;
    done = exp_req() && bus.imem_ready;
    tgt  = {16'h0, branch_target} & 32'hFFFF_FFFC;
    if (!reset_n) begin
      m_mode = 0; m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 32'h0; m_count = 0;
    end else if (branch_en && m_mode != 0) begin
      m_pc = tgt; m_valid = 1'b0; m_mode = 1;
    end else begin
      if (done) begin
        m_valid = 1'b1;
        m_instr = bus.imem_rdata;
        m_ifpc  = m_pc;
        if (m_count < 65535) m_count++;
        if (m_pc >= LAST) m_mode = 2;
        else              m_pc = m_pc + 32'd4;
      end else if (!bus.stall) begin
        m_valid = 1'b0;
      end
      if (m_mode == 0 && start) m_mode = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    bus.imem_rdata = $urandom();
  endtask

  task automatic restart();
    reset_n = 1'b0; start = 1'b0; branch_en = 1'b0; branch_target = 16'h0;
    bus.stall = 1'b0; bus.imem_ready = 1'b0;
    tick();
    reset_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; branch_en = 1'b1; branch_target = 16'h0100;
    bus.stall = 1'b0; bus.imem_ready = 1'b1;
    tick(); tick();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_req: req=%b addr=%h want 0/0", bus.imem_req, bus.imem_addr);
    end
    checks++;
    if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_if: valid=%b instr=%h pc=%h want 0", bus.if_valid, bus.if_instr,
               bus.if_pc);
    end
    checks++;
    if (halted !== 1'b0 || fetch_count !== 16'h0) begin
      errors++; $display("FAIL reset_misc: halted=%b count=%0d want 0", halted, fetch_count);
    end
    // Branch in IDLE is ignored and nothing fetches without start.
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL idle_branch: req=%b addr=%h want 0/0", bus.imem_req, bus.imem_addr);
    end
    branch_en = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] prev;
    restart();
    bus.imem_ready = 1'b1;
    prev = 32'h0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_addr[%0d]: req=%b addr=%h want 1/%h", i, bus.imem_req,
                 bus.imem_addr, 32'(4 * i));
      end
      if (i > 0) begin
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * (i - 1)) || bus.if_instr !== prev ||
            fetch_count !== 16'(i)) begin
          errors++;
          $display("FAIL stream_if[%0d]: valid=%b pc=%h instr=%h count=%0d want 1/%h/%h/%0d", i,
                   bus.if_valid, bus.if_pc, bus.if_instr, fetch_count, 32'(4 * (i - 1)), prev, i);
        end
      end
      prev = bus.imem_rdata;
      tick();
    end
  endtask

  task automatic test_wait();
    restart();
    bus.imem_ready = 1'b1;
    tick(); tick();
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || (k > 0 && bus.if_valid !== 1'b0)) begin
        errors++;
        $display("FAIL wait[%0d]: req=%b addr=%h valid=%b want 1/8/0", k, bus.imem_req,
                 bus.imem_addr, bus.if_valid);
      end
      tick();
    end
    bus.imem_ready = 1'b1;
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8 || bus.imem_addr !== 32'hC ||
        fetch_count !== 16'd3) begin
      errors++;
      $display("FAIL wait_done: valid=%b if_pc=%h addr=%h count=%0d want 1/8/c/3", bus.if_valid,
               bus.if_pc, bus.imem_addr, fetch_count);
    end
  endtask

  task automatic test_stall();
    logic [31:0] saved;
    restart();
    bus.imem_ready = 1'b1;
    tick();
    saved = bus.imem_rdata;
    tick();
    bus.stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4 ||
          bus.if_instr !== saved || fetch_count !== 16'd2) begin
        errors++;
        $display("FAIL stall[%0d]: req=%b valid=%b pc=%h instr=%h count=%0d want 0/1/4/%h/2", k,
                 bus.imem_req, bus.if_valid, bus.if_pc, bus.if_instr, fetch_count, saved);
      end
      tick();
    end
    bus.stall = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      errors++; $display("FAIL stall_resume: req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr);
    end
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8) begin
      errors++; $display("FAIL stall_next: valid=%b pc=%h want 1/8", bus.if_valid, bus.if_pc);
    end
  endtask

  task automatic test_branch();
    restart();
    bus.imem_ready = 1'b1;
    repeat (5) tick();
    branch_en = 1'b1; branch_target = 16'h0102;
    tick();
    branch_en = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h100 || fetch_count !== 16'd5 ||
        bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL branch_squash: valid=%b addr=%h count=%0d req=%b want 0/100/5/1",
               bus.if_valid, bus.imem_addr, fetch_count, bus.imem_req);
    end
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || fetch_count !== 16'd6) begin
      errors++;
      $display("FAIL branch_target: valid=%b pc=%h count=%0d want 1/100/6", bus.if_valid,
               bus.if_pc, fetch_count);
    end
  endtask

  task automatic test_halt();
    int n;
    restart();
    bus.imem_ready = 1'b1;
    n = 0;
    while (!halted && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n != 256 || halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.if_pc !== LAST ||
        fetch_count !== 16'd256) begin
      errors++;
      $display("FAIL halt: cycles=%0d halted=%b req=%b if_pc=%h count=%0d want 256/1/0/3fc/256",
               n, halted, bus.imem_req, bus.if_pc, fetch_count);
    end
    branch_en = 1'b1; branch_target = 16'h0040;
    tick();
    checks++;
    if (halted !== 1'b0 || bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL halt_exit: halted=%b addr=%h req=%b want 0/40/1", halted, bus.imem_addr,
               bus.imem_req);
    end
    // Completion at 0x40 is squashed; target beyond LAST is fetched once then halts.
    branch_target = 16'h0503;
    tick();
    branch_en = 1'b0;
    checks++;
    if (bus.imem_addr !== 32'h500 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL far_target: addr=%h valid=%b want 500/0", bus.imem_addr, bus.if_valid);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || bus.if_pc !== 32'h500 || fetch_count !== 16'd257 ||
        bus.imem_addr !== 32'h500) begin
      errors++;
      $display("FAIL far_halt: halted=%b if_pc=%h count=%0d addr=%h want 1/500/257/500", halted,
               bus.if_pc, fetch_count, bus.imem_addr);
    end
  endtask

  task automatic test_reset_midwait();
    restart();
    bus.imem_ready = 1'b1;
    repeat (32) tick();
    bus.imem_ready = 1'b0;
    tick(); tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin
      errors++; $display("FAIL midwait: req=%b addr=%h want 1/80", bus.imem_req, bus.imem_addr);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.if_valid !== 1'b0 ||
        bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0 || fetch_count !== 16'h0 ||
        halted !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset: req=%b addr=%h valid=%b pc=%h instr=%h count=%0d halted=%b",
               bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_pc, bus.if_instr, fetch_count,
               halted);
    end
    bus.imem_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.imem_req !== 1'b0 || fetch_count !== 16'h0) begin
      errors++;
      $display("FAIL midwait_idle: req=%b count=%0d want 0/0", bus.imem_req, fetch_count);
    end
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < 3000; c++) begin
      reset_n        = ($urandom_range(0, 199) != 0);
      start          = ($urandom_range(0, 9) == 0);
      bus.stall      = ($urandom_range(0, 3) == 0);
      bus.imem_ready = ($urandom_range(0, 9) < 7);
      branch_en      = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       branch_target = 16'($urandom());
        1:       branch_target = 16'(16'h03F0 + $urandom_range(0, 15));
        default: branch_target = 16'($urandom_range(0, 16'h03FF));
      endcase
      #1;
      checks++;
      if (bus.imem_req !== exp_req() || bus.imem_addr !== m_pc || bus.if_valid !== m_valid ||
          bus.if_instr !== m_instr || bus.if_pc !== m_ifpc || halted !== (m_mode == 2) ||
          fetch_count !== 16'(m_count)) begin
        errors++;
        $display("FAIL random[%0d]: req=%b/%b addr=%h/%h valid=%b/%b instr=%h/%h pc=%h/%h halt=%b/%b cnt=%0d/%0d",
                 c, bus.imem_req, exp_req(), bus.imem_addr, m_pc, bus.if_valid, m_valid,
                 bus.if_instr, m_instr, bus.if_pc, m_ifpc, halted, (m_mode == 2), fetch_count,
                 m_count);
      end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; branch_en = 1'b0; branch_target = 16'h0;
    bus.stall = 1'b0; bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_branch();
    test_halt();
    test_reset_midwait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
